// File: rtl/cp0_regfile_pkg.sv
// CP0 register file shared definitions.
// Holds the coprocessor-0 register numbers, the Status/Cause field positions, the writable-field
// masks, the architectural ExcCode values and the reset values used by cp0_regfile and cp0_timer.
package cp0_regfile_pkg;

  // mfc0/mtc0 register numbers
  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;
  localparam logic [4:0] RegPrid     = 5'd15;
  localparam logic [4:0] RegConfig   = 5'd16;

  // Status bit positions
  localparam int unsigned StatusIeBit  = 0;
  localparam int unsigned StatusExlBit = 1;
  localparam int unsigned StatusImLo   = 8;
  localparam int unsigned StatusBevBit = 22;
  localparam int unsigned StatusCu0Bit = 28;

  // Cause bit positions
  localparam int unsigned CauseExcLo = 2;
  localparam int unsigned CauseIpLo  = 8;
  localparam int unsigned CauseWpBit = 22;
  localparam int unsigned CauseIvBit = 23;
  localparam int unsigned CauseTiBit = 30;
  localparam int unsigned CauseBdBit = 31;

  // Fields an mtc0 may change: Status CU0/BEV/IM/EXL/IE, Cause IV/WP/IP[1:0]
  localparam logic [31:0] StatusWrMask = 32'h1040_FF03;
  localparam logic [31:0] CauseWrMask  = 32'h00C0_0300;

  // Reset values
  localparam logic [31:0] StatusRst = 32'h1040_0000;
  localparam logic [31:0] CauseRst  = 32'h0000_0000;
  localparam logic [31:0] EpcRst    = 32'h0000_0000;
  localparam logic [31:0] BadVaRst  = 32'h0000_0000;
  localparam logic [31:0] CountRst  = 32'h0000_0000;
  localparam logic [31:0] CompRst   = 32'h0000_0000;

  // ExcCode values
  localparam logic [4:0] ExcInt  = 5'h00;
  localparam logic [4:0] ExcMod  = 5'h01;
  localparam logic [4:0] ExcTlbl = 5'h02;
  localparam logic [4:0] ExcTlbs = 5'h03;
  localparam logic [4:0] ExcAdel = 5'h04;
  localparam logic [4:0] ExcAdes = 5'h05;
  localparam logic [4:0] ExcSys  = 5'h08;
  localparam logic [4:0] ExcBp   = 5'h09;
  localparam logic [4:0] ExcRi   = 5'h0A;
  localparam logic [4:0] ExcOv   = 5'h0C;

  // EPC points at the branch when the faulting instruction sits in its delay slot
  function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// CP0 pipeline-side bus.
// Groups the mtc0 write port, the mfc0 read port, the exception/eret commit signals, the hardware
// interrupt lines and the live register / interrupt outputs.
//   master : pipeline / exception unit side (drives requests, observes CP0 state)
//   slave  : cp0_regfile side
interface cp0_regfile_if #(
  parameter int unsigned NUM_HW_INT = 6
);
  logic                  we_i;
  logic [4:0]            waddr_i;
  logic [31:0]           wdata_i;
  logic [4:0]            raddr_i;
  logic [31:0]           rdata_o;
  logic [NUM_HW_INT-1:0] hw_int_i;
  logic                  exc_valid_i;
  logic [4:0]            exc_code_i;
  logic [31:0]           exc_pc_i;
  logic                  exc_bd_i;
  logic [31:0]           exc_badva_i;
  logic                  exc_badva_we_i;
  logic                  eret_i;
  logic [31:0]           status_o;
  logic [31:0]           cause_o;
  logic [31:0]           epc_o;
  logic                  int_req_o;
  logic                  timer_int_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, hw_int_i,
    output exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badva_i, exc_badva_we_i, eret_i,
    input  rdata_o, status_o, cause_o, epc_o, int_req_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, hw_int_i,
    input  exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badva_i, exc_badva_we_i, eret_i,
    output rdata_o, status_o, cause_o, epc_o, int_req_o, timer_int_o
  );

endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer.
// Prescaled free-running Count, Compare, and the sticky timer-interrupt flag TI.
//   clk, rst       : clock, asynchronous active-low reset
//   count_we_i     : mtc0 to Count (overrides the increment, restarts the prescaler)
//   compare_we_i   : mtc0 to Compare (clears TI)
//   wdata_i        : mtc0 data
//   count_o        : current Count
//   compare_o      : current Compare
//   ti_o           : Cause.TI
module cp0_timer
  import cp0_regfile_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic        phase_q, phase_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        inc_en;

  always_comb begin
    inc_en    = (COUNT_DIV == 1) ? 1'b1 : phase_q;
    phase_d   = (COUNT_DIV == 1) ? 1'b0 : ~phase_q;
    count_d   = inc_en ? (count_q + 32'd1) : count_q;
    compare_d = compare_q;
    ti_d      = ti_q;

    if (count_we_i) begin
      count_d = wdata_i;
      phase_d = 1'b0;
    end

    if (compare_we_i) begin
      compare_d = wdata_i;
    end

    // Match is judged on the pre-increment Count; a clear in the same cycle wins
    if (inc_en && (count_q == compare_q)) begin
      ti_d = 1'b1;
    end
    if (compare_we_i) begin
      ti_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q   <= 1'b0;
      count_q   <= CountRst;
      compare_q <= CompRst;
      ti_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file for the MIPS core.
// Holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config; sequences exception entry
// and ERET, samples hardware interrupts into Cause.IP and produces a registered masked interrupt
// request for the exception unit.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : cp0_regfile_if slave port
//              mtc0 write (we_i/waddr_i/wdata_i) from WB, mfc0 read (raddr_i -> rdata_o,
//              combinational), exception/eret commit from MEM, hw_int_i level interrupts,
//              live status_o/cause_o/epc_o, int_req_o (registered), timer_int_o (Cause.TI)
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int unsigned NUM_HW_INT = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter int unsigned TIMER_IP   = 7,
  parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input logic          clk,
  input logic          rst,
  cp0_regfile_if.slave bus
);

  localparam logic [2:0] TimerIpIdx = 3'(TIMER_IP);

  logic [31:0] badva_q, badva_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;   // only BD, IV, WP, IP[1:0] and ExcCode are stored here
  logic [31:0] epc_q, epc_d;
  logic [7:0]  hw_ip_q, hw_ip_d;   // sampled hardware lines at their Cause.IP positions
  logic        int_req_q, int_req_d;

  logic [31:0] count, compare;
  logic        ti;
  logic [7:0]  ip_vec;
  logic [31:0] cause_full;
  logic [31:0] rdata;

  logic exl;
  logic csr_blocked;
  logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;

  assign exl = status_q[StatusExlBit];

  // Exception/eret commits take Status, Cause and EPC away from a same-cycle mtc0
  assign csr_blocked = bus.exc_valid_i | bus.eret_i;
  assign wr_status   = bus.we_i & (bus.waddr_i == RegStatus) & ~csr_blocked;
  assign wr_cause    = bus.we_i & (bus.waddr_i == RegCause) & ~csr_blocked;
  assign wr_epc      = bus.we_i & (bus.waddr_i == RegEpc) & ~csr_blocked;
  assign wr_count    = bus.we_i & (bus.waddr_i == RegCount);
  assign wr_compare  = bus.we_i & (bus.waddr_i == RegCompare);

  cp0_timer #(
    .COUNT_DIV(COUNT_DIV)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .count_we_i  (wr_count),
    .compare_we_i(wr_compare),
    .wdata_i     (bus.wdata_i),
    .count_o     (count),
    .compare_o   (compare),
    .ti_o        (ti)
  );

  // Cause.IP view: sampled lines, software bits, timer folded onto its chosen IP bit
  always_comb begin
    ip_vec             = hw_ip_q;
    ip_vec[1:0]        = cause_q[CauseIpLo +: 2];
    ip_vec[TimerIpIdx] = hw_ip_q[TimerIpIdx] | ti;
  end

  always_comb begin
    cause_full                     = cause_q;
    cause_full[CauseIpLo +: 8]     = ip_vec;
    cause_full[CauseTiBit]         = ti;
  end

  always_comb begin
    hw_ip_d                  = '0;
    hw_ip_d[2 +: NUM_HW_INT] = bus.hw_int_i;
  end

  always_comb begin
    badva_d   = badva_q;
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    int_req_d = status_q[StatusIeBit] & ~exl & (|(status_q[StatusImLo +: 8] & ip_vec));

    if (bus.exc_valid_i) begin
      // Nested exceptions keep the original EPC and BD
      if (!exl) begin
        epc_d              = epc_target(bus.exc_pc_i, bus.exc_bd_i);
        cause_d[CauseBdBit] = bus.exc_bd_i;
      end
      cause_d[CauseExcLo +: 5] = bus.exc_code_i;
      status_d[StatusExlBit]   = 1'b1;
      if (bus.exc_badva_we_i) begin
        badva_d = bus.exc_badva_i;
      end
    end else if (bus.eret_i) begin
      status_d[StatusExlBit] = 1'b0;
    end

    if (wr_status) begin
      status_d = (StatusRst & ~StatusWrMask) | (bus.wdata_i & StatusWrMask);
    end
    if (wr_cause) begin
      cause_d = (cause_q & ~CauseWrMask) | (bus.wdata_i & CauseWrMask);
    end
    if (wr_epc) begin
      epc_d = bus.wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badva_q   <= BadVaRst;
      status_q  <= StatusRst;
      cause_q   <= CauseRst;
      epc_q     <= EpcRst;
      hw_ip_q   <= '0;
      int_req_q <= 1'b0;
    end else begin
      badva_q   <= badva_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      hw_ip_q   <= hw_ip_d;
      int_req_q <= int_req_d;
    end
  end

  // mfc0 read, no bypass from a same-cycle mtc0
  always_comb begin
    rdata = '0;
    case (bus.raddr_i)
      RegBadVAddr: rdata = badva_q;
      RegCount:    rdata = count;
      RegCompare:  rdata = compare;
      RegStatus:   rdata = status_q;
      RegCause:    rdata = cause_full;
      RegEpc:      rdata = epc_q;
      RegPrid:     rdata = PRID_VAL;
      RegConfig:   rdata = CONFIG_VAL;
      default:     rdata = '0;
    endcase
  end

  assign bus.rdata_o     = rdata;
  assign bus.status_o    = status_q;
  assign bus.cause_o     = cause_full;
  assign bus.epc_o       = epc_q;
  assign bus.int_req_o   = int_req_q;
  assign bus.timer_int_o = ti;

endmodule
